// File: rtl/instr_sequencer.sv
// Phase sequencer for the multi-cycle RV32 datapath: FETCH/DECODE/EXEC/MEM/WB with memory stall and watchdog.
// Optional single-step debug support is compiled in when SINGLE_STEP_EN is defined.
module instr_sequencer #(
  parameter int FETCH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        mem_access,
  input  logic        mem_ready,
  input  logic        halt_req,
`ifdef SINGLE_STEP_EN
  input  logic        step_mode,
  input  logic        step,
`endif
  output logic        ir_load,
  output logic        mem_req,
  output logic        reg_we_en,
  output logic        pc_en,
  output logic        busy,
  output logic        halted,
  output logic        mem_fault,
  output logic [2:0]  phase,
  output logic [31:0] instr_count
);

  // state  | meaning
  // IDLE   | waiting for run (or a step edge)
  // FETCH  | instruction ROM read, FETCH_CYCLES long
  // DECODE | decode
  // EXEC   | execute, samples mem_access
  // MEM    | data memory/IO request until mem_ready or watchdog
  // WB     | register write-back, PC update, samples halt_req
  // HALT   | absorbing, left only through rst
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  localparam int FW = (FETCH_CYCLES > 1) ? $clog2(FETCH_CYCLES) : 1;
  localparam logic [FW-1:0] FETCH_LAST = FW'(FETCH_CYCLES - 1);
  localparam logic [15:0]   WAIT_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [FW-1:0] fetch_cnt;
  logic [15:0]   wait_cnt;
  logic          start;
  logic          cont;

`ifdef SINGLE_STEP_EN
  logic step_prev;
  logic step_edge;

  // Step edges are only consulted in IDLE, so edges while busy are dropped.
  assign step_edge = step & ~step_prev;
  assign start     = step_mode ? step_edge : run;
  assign cont      = step_mode ? 1'b0 : run;
`else
  assign start = run;
  assign cont  = run;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      fetch_cnt   <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
      mem_fault   <= 1'b0;
`ifdef SINGLE_STEP_EN
      step_prev   <= 1'b0;
`endif
    end else begin
`ifdef SINGLE_STEP_EN
      step_prev <= step;
`endif
      case (state)
        IDLE: begin
          fetch_cnt <= '0;
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (fetch_cnt == FETCH_LAST) begin
            fetch_cnt <= '0;
            state     <= DECODE;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
        end
        DECODE: state <= EXEC;
        EXEC: begin
          wait_cnt <= '0;
          state    <= mem_access ? MEM : WB;
        end
        MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            state    <= WB;
          end else if (wait_cnt == WAIT_LAST) begin
            wait_cnt  <= '0;
            mem_fault <= 1'b1;
            state     <= HALT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        WB: begin
          instr_count <= instr_count + 32'd1;
          if (halt_req)  state <= HALT;
          else if (cont) state <= FETCH;
          else           state <= IDLE;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign phase     = state;
  assign ir_load   = (state == FETCH) && (fetch_cnt == FETCH_LAST);
  assign mem_req   = (state == MEM);
  assign reg_we_en = (state == WB);
  // halt_req is judged in the WB cycle itself, so it has to gate the PC pulse directly.
  assign pc_en     = (state == WB) && !halt_req;
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected retire records, a negedge monitor checks them.
module tb_instr_sequencer;
  localparam int FC = 2;
  localparam int MT = 8;

  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic mem_access = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
`ifdef SINGLE_STEP_EN
  logic step_mode = 1'b0, step = 1'b0;
`endif
  logic ir_load, mem_req, reg_we_en, pc_en, busy, halted, mem_fault;
  logic [2:0] phase;
  logic [31:0] instr_count;

  instr_sequencer #(.FETCH_CYCLES(FC), .MEM_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_access(mem_access), .mem_ready(mem_ready),
    .halt_req(halt_req),
`ifdef SINGLE_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .ir_load(ir_load), .mem_req(mem_req), .reg_we_en(reg_we_en), .pc_en(pc_en),
    .busy(busy), .halted(halted), .mem_fault(mem_fault), .phase(phase),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles;
    int memreq;
    int pc;
    int count;
  } exp_t;

  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int cyc = 0, mreq_n = 0, irl_cyc = 0;
  logic [2:0] prev_phase = 3'd0;

  bit plan_mem = 0, plan_halt = 0, plan_noise = 0, plan_drop = 0;
  int plan_delay = 0, mcnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks per-instruction timing and checks each write-back against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (phase == 3'd1 && prev_phase != 3'd1) begin
      cyc = 1; mreq_n = 0; irl_cyc = 0;
    end else begin
      cyc++;
    end
    if (mem_req) mreq_n++;
    if (ir_load) irl_cyc = cyc;
    if (reg_we_en) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("retire_cycle", cyc, e.cycles);
        chk("mem_req_cycles", mreq_n, e.memreq);
        chk("pc_en", pc_en, e.pc);
        chk("instr_count_in_wb", instr_count, e.count);
        chk("ir_load_cycle", irl_cyc, FC);
      end
    end
    prev_phase = phase;
  end

  // One cycle: inputs are driven at the negedge from the current plan and the observed phase.
  task automatic tick();
    @(negedge clk);
    if (phase == 3'd4) mcnt++; else mcnt = 0;
    mem_access = plan_mem;
    halt_req   = plan_halt;
    mem_ready  = (phase == 3'd4) ? (plan_delay != 0 && mcnt == plan_delay) : plan_noise;
    if (plan_drop && phase == 3'd3) run = 1'b0;
  endtask

  task automatic run_instr(input bit m, input int d, input bit h, input bit noise, input bit drop,
                           input bit retire, input int e_cyc, input int e_mreq, input int e_pc,
                           input int e_cnt);
    exp_t e;
    bit done;
    plan_mem = m; plan_delay = d; plan_halt = h; plan_noise = noise; plan_drop = drop;
    if (retire) begin
      e.cycles = e_cyc; e.memreq = e_mreq; e.pc = e_pc; e.count = e_cnt;
      sb.push_back(e);
    end
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (reg_we_en || halted) done = 1;
    end
    if (!done) chk("instr_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_mem_fault", mem_fault, 0);
    chk("rst_instr_count", instr_count, 0);
    chk("rst_pulses", {ir_load, mem_req, reg_we_en, pc_en}, 0);

    // Three back-to-back ALU instructions, one with stray mem_ready outside MEM.
    run = 1'b1;
    rst = 1'b0;
    run_instr(0, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    run_instr(0, 0, 0, 1, 0, 1, 5, 0, 1, 1);
    run_instr(0, 0, 0, 0, 0, 1, 5, 0, 1, 2);
    tick();
    chk("count_after_3", instr_count, 3);
    chk("refetch_after_wb", phase, 1);

    // Loads: ready on 4th and on 1st MEM cycle.
    run_instr(1, 4, 0, 0, 0, 1, 9, 4, 1, 3);
    run_instr(1, 1, 0, 0, 0, 1, 6, 1, 1, 4);

    // run dropped in EXEC: instruction still retires, then IDLE.
    run_instr(0, 0, 0, 0, 1, 1, 5, 0, 1, 5);
    plan_drop = 0;
    tick();
    chk("drop_run_phase", phase, 0);
    chk("drop_run_busy", busy, 0);
    chk("drop_run_count", instr_count, 6);
    tick(); tick(); tick();
    chk("idle_stays", phase, 0);

    // Halt on the 3rd instruction after a reset.
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst2_count", instr_count, 0);
    @(negedge clk); rst = 1'b0; run = 1'b1;
    run_instr(0, 0, 0, 0, 0, 1, 5, 0, 1, 0);
    run_instr(1, 2, 0, 0, 0, 1, 7, 2, 1, 1);
    run_instr(0, 0, 1, 0, 0, 1, 5, 0, 0, 2);
    tick();
    chk("halt_phase", phase, 6);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_count", instr_count, 3);
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      tick();
    end
    chk("halt_absorbing", phase, 6);
    chk("halt_count_held", instr_count, 3);
    chk("halt_no_fault", mem_fault, 0);
    @(negedge clk); rst = 1'b1; plan_halt = 0; halt_req = 1'b0;
    #1;
    chk("rst3_phase", phase, 0);
    chk("rst3_halted", halted, 0);
    chk("rst3_count", instr_count, 0);
    @(negedge clk); rst = 1'b0; run = 1'b1;

    // Memory watchdog: mem_ready never arrives.
    run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wd_mem_req_cycles", mreq_n, MT);
    chk("wd_phase", phase, 6);
    chk("wd_fault", mem_fault, 1);
    chk("wd_halted", halted, 1);
    chk("wd_count", instr_count, 0);
    chk("wd_pc_en", pc_en, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("wd_fault_sticky", mem_fault, 1);
    chk("wd_phase_sticky", phase, 6);

    // Async reset in the middle of a MEM stall.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst4_fault_clear", mem_fault, 0);
    plan_mem = 1; plan_delay = 0; plan_noise = 0;
    for (int i = 0; i < 100 && !(phase == 3'd4 && mcnt == 3); i++) tick();
    chk("mid_mem_reached", phase, 4);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_phase", phase, 0);
    chk("async_rst_mem_req", mem_req, 0);
    @(negedge clk); rst = 1'b0;
    run_instr(1, 2, 0, 0, 0, 1, 7, 2, 1, 0);

`ifdef SINGLE_STEP_EN
    // Single step: two clean step pulses retire two instructions; a pulse while busy is dropped.
    run = 1'b0; step_mode = 1'b1;
    tick();
    chk("step_idle", phase, 0);
    step = 1'b1; tick(); step = 1'b0; tick();
    step = 1'b1; tick(); step = 1'b0;
    run_instr(0, 0, 0, 0, 0, 1, 5, 0, 1, 1);
    tick();
    chk("step_back_idle", phase, 0);
    tick(); tick(); tick();
    chk("step_busy_edge_dropped", phase, 0);
    step = 1'b1;
    run_instr(0, 0, 0, 0, 0, 1, 5, 0, 1, 2);
    step = 1'b0;
    tick();
    chk("step_back_idle2", phase, 0);
    chk("step_count", instr_count, 3);
`endif

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
